// File: rtl/prj_definition.sv
// Shared definitions for the cs147sec05 multi-cycle control unit: CTRL bit
// positions, opcode/funct values, ALU operation codes and state encodings.
package prj_definition;

  localparam int CTRL_WIDTH_INDEX_LIMIT = 31;

  localparam int CTRL_PC_LOAD   = 0;
  localparam int CTRL_PC_SEL_1  = 1;
  localparam int CTRL_PC_SEL_2  = 2;
  localparam int CTRL_PC_SEL_3  = 3;
  localparam int CTRL_IR_LOAD   = 4;
  localparam int CTRL_MEM_R     = 5;
  localparam int CTRL_MEM_W     = 6;
  localparam int CTRL_R1_SEL_1  = 7;
  localparam int CTRL_REG_R     = 8;
  localparam int CTRL_REG_W     = 9;
  localparam int CTRL_WA_SEL_1  = 10;
  localparam int CTRL_WA_SEL_2  = 11;
  localparam int CTRL_WA_SEL_3  = 12;
  localparam int CTRL_WD_SEL_1  = 13;
  localparam int CTRL_WD_SEL_2  = 14;
  localparam int CTRL_WD_SEL_3  = 15;
  localparam int CTRL_SP_LOAD   = 16;
  localparam int CTRL_OP1_SEL_1 = 17;
  localparam int CTRL_OP2_SEL_1 = 18;
  localparam int CTRL_ALU_LSB   = 22;
  localparam int CTRL_MA_SEL_1  = 26;
  localparam int CTRL_MA_SEL_2  = 27;
  localparam int CTRL_MD_SEL_1  = 28;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHL  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;

  // op2 = sel_4 ? R2 : sel_3 ? (sel_2 ? {imm,16'b0} : sel_1 ? sext(imm) : zext(imm))
  //                          : (sel_1 ? shamt : 1); bits listed {sel_4,sel_3,sel_2,sel_1}
  localparam logic [3:0] OP2_ONE   = 4'b0000;
  localparam logic [3:0] OP2_SHAMT = 4'b0001;
  localparam logic [3:0] OP2_ZEXT  = 4'b0100;
  localparam logic [3:0] OP2_SEXT  = 4'b0101;
  localparam logic [3:0] OP2_LUI   = 4'b0110;
  localparam logic [3:0] OP2_R2    = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXE    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic       r_alu;
    logic       i_alu;
    logic       is_lui;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_jmp;
    logic       is_jal;
    logic       is_jr;
    logic       is_push;
    logic       is_pop;
    logic       op1_sel_1;
    logic [3:0] op2_sel;
    logic [3:0] alu_oprn;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction classifier: class flags plus the ALU operation
// and operand selects an instruction needs from EXE onward.
module instr_decoder
  import prj_definition::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  always_comb begin
    dec = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.r_alu   = 1'b1;
        dec.op2_sel = OP2_R2;
        case (funct)
          FN_ADD: dec.alu_oprn = ALU_ADD;
          FN_SUB: dec.alu_oprn = ALU_SUB;
          FN_MUL: dec.alu_oprn = ALU_MUL;
          FN_AND: dec.alu_oprn = ALU_AND;
          FN_OR:  dec.alu_oprn = ALU_OR;
          FN_NOR: dec.alu_oprn = ALU_NOR;
          FN_SLT: dec.alu_oprn = ALU_SLT;
          FN_SLL: begin dec.alu_oprn = ALU_SHL; dec.op2_sel = OP2_SHAMT; end
          FN_SRL: begin dec.alu_oprn = ALU_SHR; dec.op2_sel = OP2_SHAMT; end
          FN_JR: begin
            dec.r_alu   = 1'b0;
            dec.op2_sel = OP2_ONE;
            dec.is_jr   = 1'b1;
          end
          default: begin
            // Unknown funct behaves as a NOP: no ALU, no write-back.
            dec.r_alu   = 1'b0;
            dec.op2_sel = OP2_ONE;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin dec.i_alu = 1'b1; dec.alu_oprn = ALU_ADD; dec.op2_sel = OP2_SEXT; end
      OP_MULI: begin dec.i_alu = 1'b1; dec.alu_oprn = ALU_MUL; dec.op2_sel = OP2_SEXT; end
      OP_ANDI: begin dec.i_alu = 1'b1; dec.alu_oprn = ALU_AND; dec.op2_sel = OP2_ZEXT; end
      OP_ORI:  begin dec.i_alu = 1'b1; dec.alu_oprn = ALU_OR;  dec.op2_sel = OP2_ZEXT; end
      OP_SLTI: begin dec.i_alu = 1'b1; dec.alu_oprn = ALU_SLT; dec.op2_sel = OP2_SEXT; end
      OP_LUI: begin
        dec.i_alu    = 1'b1;
        dec.is_lui   = 1'b1;
        dec.alu_oprn = ALU_ADD;
        dec.op2_sel  = OP2_LUI;
      end
      OP_BEQ:  begin dec.is_beq = 1'b1; dec.alu_oprn = ALU_SUB; dec.op2_sel = OP2_R2; end
      OP_BNE:  begin dec.is_bne = 1'b1; dec.alu_oprn = ALU_SUB; dec.op2_sel = OP2_R2; end
      OP_LW:   begin dec.is_lw  = 1'b1; dec.alu_oprn = ALU_ADD; dec.op2_sel = OP2_SEXT; end
      OP_SW:   begin dec.is_sw  = 1'b1; dec.alu_oprn = ALU_ADD; dec.op2_sel = OP2_SEXT; end
      OP_JMP:  dec.is_jmp = 1'b1;
      OP_JAL:  dec.is_jal = 1'b1;
      OP_PUSH: begin
        dec.is_push   = 1'b1;
        dec.op1_sel_1 = 1'b1;
        dec.alu_oprn  = ALU_SUB;
        dec.op2_sel   = OP2_ONE;
      end
      OP_POP: begin
        dec.is_pop    = 1'b1;
        dec.op1_sel_1 = 1'b1;
        dec.alu_oprn  = ALU_ADD;
        dec.op2_sel   = OP2_ONE;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: state register plus per-state assembly of the
// CTRL word from the decoded instruction and the ALU ZERO flag.
module control_unit
  import prj_definition::*;
#(
  parameter int CTRL_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic [2:0]        STATE,
  output logic              ILLEGAL
);

  state_t            state_reg;
  state_t            state_next;
  dec_t              dec;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [CTRL_W-1:0] ctrl;
  logic              wb_rd;
  logic              wb_rt;

  instr_decoder u_decoder (
    .instruction (INSTRUCTION),
    .dec         (dec)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // ALU selections stay asserted from EXE through WB so the result is stable.
  always_comb begin
    alu_ctrl = '0;
    alu_ctrl[CTRL_OP1_SEL_1] = dec.op1_sel_1;
    alu_ctrl[CTRL_OP2_SEL_1 +: 4] = dec.op2_sel;
    alu_ctrl[CTRL_ALU_LSB +: 4] = dec.alu_oprn;
  end

  assign wb_rd = dec.r_alu;
  assign wb_rt = dec.i_alu | dec.is_lw | dec.is_pop;

  always_comb begin
    ctrl       = '0;
    ILLEGAL    = 1'b0;
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        state_next            = ST_DECODE;
        ctrl[CTRL_MEM_R]      = 1'b1;
        ctrl[CTRL_MA_SEL_2]   = 1'b1;
        ctrl[CTRL_IR_LOAD]    = 1'b1;
      end
      ST_DECODE: begin
        state_next            = ST_EXE;
        ctrl[CTRL_REG_R]      = 1'b1;
        ctrl[CTRL_R1_SEL_1]   = dec.is_lui;
        ILLEGAL               = dec.illegal;
      end
      ST_EXE: begin
        state_next = ST_MEM;
        ctrl       = alu_ctrl;
      end
      ST_MEM: begin
        state_next            = ST_WB;
        ctrl                  = alu_ctrl;
        ctrl[CTRL_MEM_R]      = dec.is_lw | dec.is_pop;
        ctrl[CTRL_MEM_W]      = dec.is_sw | dec.is_push;
        ctrl[CTRL_MA_SEL_1]   = dec.is_push | dec.is_pop;
        ctrl[CTRL_MD_SEL_1]   = dec.is_push;
      end
      ST_WB: begin
        state_next            = ST_FETCH;
        ctrl                  = alu_ctrl;
        ctrl[CTRL_PC_LOAD]    = 1'b1;
        ctrl[CTRL_PC_SEL_1]   = ~dec.is_jr;
        ctrl[CTRL_PC_SEL_2]   = (dec.is_beq & ZERO) | (dec.is_bne & ~ZERO);
        ctrl[CTRL_PC_SEL_3]   = ~(dec.is_jmp | dec.is_jal);
        ctrl[CTRL_REG_W]      = wb_rd | wb_rt | dec.is_jal;
        ctrl[CTRL_WA_SEL_1]   = wb_rt;
        ctrl[CTRL_WA_SEL_3]   = wb_rd | wb_rt;
        ctrl[CTRL_WD_SEL_1]   = dec.is_lw | dec.is_pop;
        ctrl[CTRL_WD_SEL_3]   = wb_rd | wb_rt;
        ctrl[CTRL_SP_LOAD]    = dec.is_push | dec.is_pop;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign CTRL  = ctrl;
  assign STATE = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit: each vector is walked through
// all five states and STATE, CTRL and ILLEGAL are compared in every state.
module tb_control_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic [2:0]  STATE;
  logic        ILLEGAL;

  int errors = 0;
  int checks = 0;

  control_unit #(.CTRL_W(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .CTRL        (CTRL),
    .STATE       (STATE),
    .ILLEGAL     (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic        ill;
    logic [31:0] dec;
    logic [31:0] exe;
    logic [31:0] mem;
    logic [31:0] wb;
  } vec_t;

  localparam logic [31:0] FETCH_CTRL = 32'h0800_0030;
  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] st, input logic [31:0] c,
                           input logic ill);
    chk({tag, " STATE"}, {29'd0, STATE}, {29'd0, st});
    chk({tag, " CTRL"}, CTRL, c);
    chk({tag, " ILLEGAL"}, {31'd0, ILLEGAL}, {31'd0, ill});
  endtask

  task automatic run_vec(input vec_t v);
    INSTRUCTION = v.instr;
    ZERO        = v.zero;
    #1;
    chk_state({v.name, " fetch"}, 3'd1, FETCH_CTRL, 1'b0);
    step();
    chk_state({v.name, " decode"}, 3'd2, v.dec, v.ill);
    step();
    chk_state({v.name, " exe"}, 3'd3, v.exe, 1'b0);
    step();
    chk_state({v.name, " mem"}, 3'd4, v.mem, 1'b0);
    step();
    chk_state({v.name, " wb"}, 3'd5, v.wb, 1'b0);
    step();
    $display("vector %-8s instr=%h zero=%0d wb_ctrl=%h errors=%0d", v.name, v.instr, v.zero,
             v.wb, errors);
  endtask

  initial begin
    vecs[0]  = '{"add",    32'h0022_1820, 1'b0, 1'b0, 32'h100, 32'h0060_0000, 32'h0060_0000, 32'h0060_920B};
    vecs[1]  = '{"sll",    32'h0001_1081, 1'b0, 1'b0, 32'h100, 32'h0144_0000, 32'h0144_0000, 32'h0144_920B};
    vecs[2]  = '{"jr",     32'h0020_0008, 1'b0, 1'b0, 32'h100, 32'h0,         32'h0,         32'h0000_0009};
    vecs[3]  = '{"badfn",  32'h0000_003F, 1'b0, 1'b1, 32'h100, 32'h0,         32'h0,         32'h0000_000B};
    vecs[4]  = '{"lw",     32'h8C22_0004, 1'b0, 1'b0, 32'h100, 32'h0054_0000, 32'h0054_0020, 32'h0054_B60B};
    vecs[5]  = '{"sw",     32'hAC22_0004, 1'b0, 1'b0, 32'h100, 32'h0054_0000, 32'h0054_0040, 32'h0054_000B};
    vecs[6]  = '{"lui",    32'h3C01_ABCD, 1'b0, 1'b0, 32'h180, 32'h0058_0000, 32'h0058_0000, 32'h0058_960B};
    vecs[7]  = '{"beq_z1", 32'h1022_0003, 1'b1, 1'b0, 32'h100, 32'h00A0_0000, 32'h00A0_0000, 32'h00A0_000F};
    vecs[8]  = '{"beq_z0", 32'h1022_0003, 1'b0, 1'b0, 32'h100, 32'h00A0_0000, 32'h00A0_0000, 32'h00A0_000B};
    vecs[9]  = '{"bne_z0", 32'h1422_0003, 1'b0, 1'b0, 32'h100, 32'h00A0_0000, 32'h00A0_0000, 32'h00A0_000F};
    vecs[10] = '{"bne_z1", 32'h1422_0003, 1'b1, 1'b0, 32'h100, 32'h00A0_0000, 32'h00A0_0000, 32'h00A0_000B};
    vecs[11] = '{"jal",    32'h0C00_0010, 1'b0, 1'b0, 32'h100, 32'h0,         32'h0,         32'h0000_0203};
    vecs[12] = '{"jmp",    32'h0800_0010, 1'b0, 1'b0, 32'h100, 32'h0,         32'h0,         32'h0000_0003};
    vecs[13] = '{"push",   32'h6C20_0000, 1'b0, 1'b0, 32'h100, 32'h0082_0000, 32'h1482_0040, 32'h0083_000B};
    vecs[14] = '{"pop",    32'h7002_0000, 1'b0, 1'b0, 32'h100, 32'h0042_0000, 32'h0442_0020, 32'h0043_B60B};
    vecs[15] = '{"illop",  32'hFC00_0000, 1'b1, 1'b1, 32'h100, 32'h0,         32'h0,         32'h0000_000B};
    vecs[16] = '{"andi",   32'h3022_0FFF, 1'b0, 1'b0, 32'h100, 32'h0190_0000, 32'h0190_0000, 32'h0190_960B};

    RST         = 1'b0;
    INSTRUCTION = 32'h0022_1820;
    ZERO        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state("reset", 3'd0, 32'h0, 1'b0);
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
    $display("reset released, state=%0d", STATE);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset asserted in the middle of an sw's MEM state.
    INSTRUCTION = 32'hAC22_0004;
    ZERO        = 1'b0;
    step();
    step();
    step();
    chk("midrst pre mem_w", {31'd0, CTRL[6]}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst CTRL", CTRL, 32'h0);
    chk("midrst STATE", {29'd0, STATE}, 32'd0);
    step();
    chk("midrst hold STATE", {29'd0, STATE}, 32'd0);
    chk("midrst hold CTRL", CTRL, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    step();
    $display("mid-instruction reset released, state=%0d", STATE);
    run_vec(vecs[5]);
    chk("after sw refetch STATE", {29'd0, STATE}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control unit for the 32-bit cs147sec05 processor; drives the 32-bit CTRL word consumed by the data path.
- Inputs are the instruction register contents (INSTRUCTION) and the ALU ZERO flag returned by the data path.
- Sequences every instruction through FETCH, DECODE, EXE, MEM, WB. Together with the data path and memory it forms the processor top.

Parameters:
- CTRL_W, 32, CTRL word width; bits 29-31 are reserved and held 0.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  32  current IR value from the data path.
- ZERO  in  1  ALU zero flag, valid during EXE and later states.
- CTRL  out  32  control word; bit map is in Behaviour.
- STATE  out  3  current state: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXE, 4 MEM, 5 WB.
- ILLEGAL  out  1  high during DECODE for an unknown opcode or funct.

Behaviour:
- CTRL bit map:
  - [0] pc_load, [1] pc_sel_1, [2] pc_sel_2, [3] pc_sel_3, [4] ir_load, [5] mem_r, [6] mem_w, [7] r1_sel_1
  - [8] reg_r, [9] reg_w, [10-12] wa_sel_1..3, [13-15] wd_sel_1..3, [16] sp_load, [17] op1_sel_1
  - [18-21] op2_sel_1..4, [25:22] alu_oprn, [26] ma_sel_1, [27] ma_sel_2, [28] md_sel_1
- Mux meanings:
  - pc_sel_1: 1 = PC+1, 0 = R1 (jr).
  - pc_sel_2: 1 = PC+1+sign-extended imm.
  - pc_sel_3: 0 = {6'b0, addr26}.
  - ma_sel_2: 1 = address is PC.
  - ma_sel_1: 1 = address is SP.
  - wa_sel_3: 0 = r31.
  - wd_sel_3: 0 = PC+1.
- Register semantics: only the state register is sequential. CTRL, ILLEGAL and STATE are combinational functions of the state and INSTRUCTION, plus ZERO in WB.
- Reset while RST=0:
  - state is IDLE and CTRL = 0.
  - This applies immediately, including mid-instruction: no memory write or register write is asserted during reset.
- Sequencing:
  - The first rising edge after RST deasserts moves IDLE to FETCH.
  - After that the state advances FETCH, DECODE, EXE, MEM, WB, FETCH. Each state lasts exactly one cycle, for all opcodes, so every instruction takes 5 cycles.
- FETCH: mem_r=1, ma_sel_2=1, ir_load=1. IR captures DATA at the end of the cycle.
- DECODE:
  - reg_r=1.
  - r1_sel_1=1 for lui; otherwise r1_sel_1=0 (R1 = rs).
  - ILLEGAL=1 for an unrecognised opcode, or for an unrecognised funct under opcode 0x00. The instruction then executes as a NOP (PC+1 only).
- EXE, alu_oprn encodings: add 1, sub 2, mul 3, shr 4, shl 5, and 6, or 7, nor 8, slt 9.
- EXE, R-type (opcode 0x00):
  - funct 0x20 add, 0x22 sub, 0x2c mul, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt.
  - funct 0x01 sll and 0x02 srl: op2 is shamt.
  - funct 0x08 jr: no ALU use.
- EXE, I-type:
  - addi 0x08 and muli 0x1d: op2 is sign-extended imm.
  - andi 0x0c and ori 0x0d: op2 is zero-extended imm.
  - lui 0x0f: op2 is {imm, 16'b0}, alu add.
  - slti 0x0a.
  - beq 0x04 and bne 0x05: alu sub.
  - lw 0x23 and sw 0x2b: add with sign-extended imm.
- EXE, J-type: jmp 0x02, jal 0x03 (no ALU use).
- EXE, stack ops:
  - push 0x1b: SP-1.
  - pop 0x1c: SP+1.
- MEM:
  - lw: mem_r=1, ma_sel=ALU.
  - sw: mem_w=1.
  - push: mem_w=1, ma_sel_1=1, md_sel_1=1 (data = R1 from rs).
  - pop: mem_r=1, ma_sel_1=1.
  - All other opcodes: CTRL carries the EXE ALU selections only, with no memory strobes.
- WB:
  - pc_load=1 always.
  - Default next PC is PC+1.
  - beq takes the branch when ZERO=1; bne takes it when ZERO=0. A taken branch selects pc_sel_2=1.
  - jmp selects pc_sel_3=0.
  - jal selects pc_sel_3=0, reg_w=1, wa=r31, wd=PC+1.
  - jr selects pc_sel_1=0.
- WB register writes:
  - reg_w=1 for R-type ALU ops with wa=rd.
  - reg_w=1 for I-type ALU ops and lw with wa=rt.
  - reg_w=1 for pop with wa=rt and data from memory.
- WB stack pointer: sp_load=1 for push and pop.
- WB no register write for sw, beq, bne, jmp, jr, push.
- Single-cycle strobes: mem_w and reg_w are never both high in the same cycle. pc_load and ir_load are each high for exactly one cycle per instruction.

Decomposition:
- Shared package prj_definition:
  - CTRL bit-index constants.
  - Opcode and funct constants.
  - alu_oprn encodings.
  - State encodings.
  - CTRL_WIDTH_INDEX_LIMIT.
- Sub-module instr_decoder (combinational):
  - Input: INSTRUCTION.
  - Outputs: per-instruction class flags, ALU op and operand-select fields.
  - control_unit keeps the state register and assembles CTRL per state.

Test Plan:
- Reset then run: hold RST=0 for 3 cycles, then release.
  - CTRL must be 0 and STATE=0 throughout reset.
  - STATE must then read 1,2,3,4,5,1. In FETCH, CTRL must have bits 4, 5 and 27 set.
- add (INSTRUCTION=32'h00221820):
  - EXE alu_oprn must be 1.
  - WB must assert reg_w with wa=rd (3) and pc_load=1.
  - mem_w must stay 0 in every state.
- beq with ZERO=1, then ZERO=0:
  - With ZERO=1, WB must have pc_sel_2=1.
  - With ZERO=0, WB must have pc_sel_1=1 and pc_sel_2=0.
  - bne must give the inverse.
- sw (32'hAC220004): MEM must assert mem_w=1 for exactly one cycle, and WB must have reg_w=0.
- jal (32'h0C000010): WB must have pc_sel_3=0, reg_w=1, wa=r31 and wd=PC+1.
- Illegal opcode 0x3F:
  - ILLEGAL must be high in DECODE.
  - WB must perform only PC+1.
- Reset mid-instruction: drive RST=0 during MEM of an sw.
  - mem_w must drop to 0 immediately, without waiting for a clock edge.
  - After release, the sequence must restart at FETCH.
